// File: rtl/prog_sequencer_pkg.sv
// Shared definitions for the program-load sequencer: control-word bit map,
// idle control word and the FSM state encoding.
package prog_sequencer_pkg;

    localparam int CTRL_W = 15;

    localparam int B_PC_INC          = 14;
    localparam int B_PC_EN           = 13;
    localparam int B_PC_LOAD         = 12;
    localparam int B_MAR_ADDR_LOAD_N = 11;
    localparam int B_MAR_MEM_LOAD_N  = 10;
    localparam int B_RAM_EN_N        = 9;
    localparam int B_RAM_LOAD_N      = 8;
    localparam int B_IR_LOAD_N       = 7;
    localparam int B_IR_EN_N         = 6;
    localparam int B_REGA_LOAD_N     = 5;
    localparam int B_REGA_EN         = 4;
    localparam int B_ADDER_SUB       = 3;
    localparam int B_REGB_EN         = 2;
    localparam int B_REGB_LOAD_N     = 1;
    localparam int B_OUT_LOAD_N      = 0;

    // Every strobe deasserted: active-low bits high, active-high bits low.
    localparam logic [CTRL_W-1:0] CTRL_IDLE = 15'h0FE3;

    localparam logic [CTRL_W-1:0] CTRL_LOW_MASK =
        CTRL_W'((1 << B_MAR_ADDR_LOAD_N) | (1 << B_MAR_MEM_LOAD_N) | (1 << B_RAM_EN_N) |
                (1 << B_RAM_LOAD_N) | (1 << B_IR_LOAD_N) | (1 << B_IR_EN_N) |
                (1 << B_REGA_LOAD_N) | (1 << B_REGB_LOAD_N) | (1 << B_OUT_LOAD_N));

    localparam logic [CTRL_W-1:0] CTRL_HIGH_MASK =
        CTRL_W'((1 << B_PC_INC) | (1 << B_PC_EN) | (1 << B_PC_LOAD) |
                (1 << B_REGA_EN) | (1 << B_ADDER_SUB) | (1 << B_REGB_EN));

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_ARMED  = 3'd2,
        S_ADDR   = 3'd3,
        S_DATA   = 3'd4,
        S_WRITE  = 3'd5,
        S_INC    = 3'd6,
        S_FINISH = 3'd7
    } seq_state_e;

    // Control word driven while the FSM sits in state s.
    function automatic logic [CTRL_W-1:0] ctrl_for_state(input seq_state_e s);
        logic [CTRL_W-1:0] w;
        w = CTRL_IDLE;
        case (s)
            S_CLEAR: w[B_PC_LOAD] = 1'b1;
            S_ADDR: begin
                w[B_PC_EN]           = 1'b1;
                w[B_MAR_ADDR_LOAD_N] = 1'b0;
            end
            S_DATA:  w[B_MAR_MEM_LOAD_N] = 1'b0;
            S_WRITE: w[B_RAM_LOAD_N]     = 1'b0;
            S_INC:   w[B_PC_INC]         = 1'b1;
            default: w = CTRL_IDLE;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/prog_sequencer_pending.sv
// One-deep holding slot for a program byte that arrives while the previous
// byte is still being written. A push into an occupied slot is refused and
// flagged on drop_o; a simultaneous pop frees the slot for the push.
module prog_pending_slot (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] data_i,
    output logic       valid_o,
    output logic [7:0] data_o,
    output logic       drop_o
);

    logic       valid_q, valid_d;
    logic [7:0] data_q, data_d;

    assign drop_o  = push_i & valid_q & ~pop_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    // Next slot contents: clear wins, then pop, then an accepted push.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clr_i) begin
            valid_d = 1'b0;
        end else begin
            if (pop_i) valid_d = 1'b0;
            if (push_i && !drop_o) begin
                valid_d = 1'b1;
                data_d  = data_i;
            end
        end
    end

    // Slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/prog_sequencer.sv
// Program-load sequencer: takes bytes strobed in on ui_in while a load
// session is open and drives the CPU control word / shared bus to store each
// one at the next program address.
//
// state  | meaning
// IDLE   | no session, bus released, control word idle
// CLEAR  | reset PC to 0 (bus 0x00, PC_LOAD), session counters cleared
// ARMED  | waiting for a byte, or for programming to drop
// ADDR   | PC onto bus, MAR address load
// DATA   | byte onto bus, MAR memory-register load
// WRITE  | byte onto bus, RAM write
// INC    | PC increment, byte_count advanced
// FINISH | one-cycle done pulse, then IDLE
module prog_sequencer
    import prog_sequencer_pkg::*;
#(
    parameter int RAM_DEPTH = 16,
    parameter int CNT_W     = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [7:0]        ui_in,
    input  logic              programming,
    input  logic              new_byte,
    output logic [7:0]        bus_out,
    output logic              bus_oe,
    output logic [CTRL_W-1:0] ctrl,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  byte_count,
    output logic              full,
    output logic              overrun
);

    if (CNT_W != $clog2(RAM_DEPTH) + 1) begin : g_bad_cnt_w
        $error("CNT_W must be log2(RAM_DEPTH)+1");
    end
    if ((CTRL_IDLE != CTRL_LOW_MASK) || ((CTRL_IDLE & CTRL_HIGH_MASK) != '0)) begin : g_bad_idle
        $error("idle control word inconsistent with bit map");
    end

    seq_state_e        state_q, state_d;
    logic              prog_q;
    logic              edge_ok_q;
    logic [7:0]        data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              full_q;
    logic              ovr_q;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [7:0]        bus_q, bus_d;
    logic              oe_q, oe_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic       slot_clr, slot_push, slot_pop;
    logic       slot_valid, slot_drop;
    logic [7:0] slot_data;
    logic       ovr_set, ovr_clr;
    logic       byte_phase;
    logic       prog_rise;

    // edge_ok_q blocks a session when programming is already high as reset
    // releases: a rise only counts once programming has been seen low.
    assign prog_rise  = programming & ~prog_q & edge_ok_q;
    assign byte_phase = (state_q == S_ADDR) || (state_q == S_DATA) ||
                        (state_q == S_WRITE) || (state_q == S_INC);

    prog_pending_slot u_slot (
        .clk    (clk),
        .rst_n  (resetn),
        .clr_i  (slot_clr),
        .push_i (slot_push),
        .pop_i  (slot_pop),
        .data_i (ui_in),
        .valid_o(slot_valid),
        .data_o (slot_data),
        .drop_o (slot_drop)
    );

    // Next-state, byte latch, counter and slot control.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        slot_clr  = 1'b0;
        slot_push = 1'b0;
        slot_pop  = 1'b0;
        ovr_set   = 1'b0;
        ovr_clr   = 1'b0;

        if (byte_phase && new_byte) begin
            if (full_q) ovr_set   = 1'b1;
            else        slot_push = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (prog_rise) begin
                    state_d  = S_CLEAR;
                    cnt_d    = '0;
                    ovr_clr  = 1'b1;
                    slot_clr = 1'b1;
                end
            end
            S_CLEAR: state_d = S_ARMED;
            S_ARMED: begin
                if (slot_valid) begin
                    slot_pop = 1'b1;
                    // A byte parked while the last free location was being
                    // written has nowhere to go: discard it as an overrun.
                    if (full_q) begin
                        ovr_set = 1'b1;
                    end else begin
                        data_d  = slot_data;
                        state_d = S_ADDR;
                    end
                    if (new_byte) begin
                        if (full_q) ovr_set   = 1'b1;
                        else        slot_push = 1'b1;
                    end
                    if (full_q && !programming) state_d = S_FINISH;
                end else if (new_byte && !full_q) begin
                    data_d  = ui_in;
                    state_d = S_ADDR;
                end else begin
                    ovr_set = new_byte;
                    if (!programming) state_d = S_FINISH;
                end
            end
            S_ADDR:  state_d = S_DATA;
            S_DATA:  state_d = S_WRITE;
            S_WRITE: begin
                state_d = S_INC;
                cnt_d   = cnt_q + 1'b1;
            end
            S_INC:    state_d = S_ARMED;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state so every output is a flop aligned
    // with the state it belongs to.
    always_comb begin
        ctrl_d = ctrl_for_state(state_d);
        oe_d   = (state_d == S_CLEAR) || (state_d == S_DATA) || (state_d == S_WRITE);
        bus_d  = ((state_d == S_DATA) || (state_d == S_WRITE)) ? data_d : 8'h00;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FINISH);
    end

    // State, latched byte, counters and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            prog_q    <= 1'b0;
            edge_ok_q <= 1'b0;
            data_q    <= 8'h00;
            cnt_q     <= '0;
            full_q    <= 1'b0;
            ctrl_q    <= CTRL_IDLE;
            bus_q     <= 8'h00;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prog_q    <= programming;
            edge_ok_q <= edge_ok_q | ~programming;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            full_q    <= (cnt_d == CNT_W'(RAM_DEPTH));
            ctrl_q    <= ctrl_d;
            bus_q     <= bus_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Sticky overrun: cleared only when a new session starts.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                   ovr_q <= 1'b0;
        else if (ovr_clr)              ovr_q <= 1'b0;
        else if (ovr_set || slot_drop) ovr_q <= 1'b1;
    end

    assign bus_out    = bus_q;
    assign bus_oe     = oe_q;
    assign ctrl       = ctrl_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign byte_count = cnt_q;
    assign full       = full_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: directed scenarios with literal expectations,
// then randomized sessions checked every cycle against a behavioural model.
module tb_prog_sequencer;

    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [7:0]    ui_in = 8'h00;
    logic          programming = 1'b0;
    logic          new_byte = 1'b0;
    logic [7:0]    bus_out;
    logic          bus_oe;
    logic [14:0]   ctrl;
    logic          busy;
    logic          done;
    logic [CW-1:0] byte_count;
    logic          full;
    logic          overrun;

    int checks = 0;
    int errors = 0;

    prog_sequencer #(.RAM_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ui_in      (ui_in),
        .programming(programming),
        .new_byte   (new_byte),
        .bus_out    (bus_out),
        .bus_oe     (bus_oe),
        .ctrl       (ctrl),
        .busy       (busy),
        .done       (done),
        .byte_count (byte_count),
        .full       (full),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 clearing, 2 in session, 3 finishing
    // stage within session: 0 waiting for a byte, 1..4 = the four write cycles
    int         m_mode = 0;
    int         m_stage = 0;
    int         m_cnt = 0;
    bit         m_ovr = 1'b0;
    bit         m_prev = 1'b0;
    bit         m_seen_low = 1'b0;
    bit [7:0]   m_cur = 8'h00;
    bit [7:0]   m_pend[$];

    task automatic model_reset();
        m_mode = 0; m_stage = 0; m_cnt = 0; m_ovr = 1'b0;
        m_prev = 1'b0; m_seen_low = 1'b0; m_cur = 8'h00;
        m_pend.delete();
    endtask

    task automatic model_step(input bit p, input bit nb, input bit [7:0] d);
        bit full_now;
        bit [7:0] b;
        full_now = (m_cnt == DEPTH);
        case (m_mode)
            0: if (p && !m_prev && m_seen_low) begin
                m_mode = 1; m_cnt = 0; m_ovr = 1'b0; m_pend.delete();
            end
            1: begin m_mode = 2; m_stage = 0; end
            2: if (m_stage != 0) begin
                if (nb) begin
                    if (full_now || m_pend.size() != 0) m_ovr = 1'b1;
                    else m_pend.push_back(d);
                end
                m_stage = (m_stage == 4) ? 0 : m_stage + 1;
                if (m_stage == 4) m_cnt++;
            end else if (m_pend.size() != 0) begin
                b = m_pend.pop_front();
                if (full_now) m_ovr = 1'b1;
                else begin m_cur = b; m_stage = 1; end
                if (nb) begin
                    if (full_now) m_ovr = 1'b1;
                    else m_pend.push_back(d);
                end
                if (full_now && !p) m_mode = 3;
            end else if (nb && !full_now) begin
                m_cur = d; m_stage = 1;
            end else begin
                if (nb) m_ovr = 1'b1;
                if (!p) m_mode = 3;
            end
            default: m_mode = 0;
        endcase
        m_prev = p;
        if (!p) m_seen_low = 1'b1;
    endtask

    function automatic logic [14:0] model_ctrl();
        logic [14:0] w;
        w = 15'((1 << 11) | (1 << 10) | (1 << 9) | (1 << 8) | (1 << 7) |
                (1 << 6) | (1 << 5) | (1 << 1) | (1 << 0));
        if (m_mode == 1) w[12] = 1'b1;
        if (m_mode == 2) begin
            case (m_stage)
                1: begin w[13] = 1'b1; w[11] = 1'b0; end
                2: w[10] = 1'b0;
                3: w[8] = 1'b0;
                4: w[14] = 1'b1;
                default: ;
            endcase
        end
        return w;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) model_reset();
        else model_step(programming, new_byte, ui_in);
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (resetn) begin
            chk("ctrl", ctrl, model_ctrl());
            chk("bus_oe", bus_oe, (m_mode == 1) || (m_mode == 2 && (m_stage == 2 || m_stage == 3)));
            chk("bus_out", bus_out, (m_mode == 2 && (m_stage == 2 || m_stage == 3)) ? m_cur : 8'h00);
            chk("busy", busy, m_mode != 0);
            chk("done", done, m_mode == 3);
            chk("byte_count", byte_count, m_cnt);
            chk("full", full, m_cnt == DEPTH);
            chk("overrun", overrun, m_ovr);
        end
    end

    // Bytes seen on the bus during RAM write cycles.
    bit [7:0] written[$];
    always @(negedge clk) begin
        if (resetn && ctrl[8] == 1'b0) written.push_back(bus_out);
    end

    // ---------------- stimulus helpers ----------------
    task automatic strobe(input logic [7:0] b);
        new_byte = 1'b1;
        ui_in    = b;
        @(negedge clk);
        new_byte = 1'b0;
    endtask

    // Leaves the bench at the negedge where the sequencer is first ARMED.
    task automatic start_session();
        programming = 1'b0;
        repeat (10) @(negedge clk);
        programming = 1'b1;
        @(negedge clk);
        @(negedge clk);
        written.delete();
    endtask

    int dn;
    int rate;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ctrl", ctrl, 15'h0FE3);
        chk("rst_busy", busy, 0);
        chk("rst_oe", bus_oe, 0);
        chk("rst_cnt", byte_count, 0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        // single byte A5
        programming = 1'b1;
        @(negedge clk);
        chk("t1_clear_ctrl", ctrl, 15'h1FE3);
        chk("t1_clear_oe", bus_oe, 1);
        chk("t1_clear_bus", bus_out, 8'h00);
        @(negedge clk);
        chk("t1_armed_ctrl", ctrl, 15'h0FE3);
        written.delete();
        strobe(8'hA5);
        chk("t1_addr_ctrl", ctrl, 15'h27E3);
        @(negedge clk);
        chk("t1_data_ctrl", ctrl, 15'h0BE3);
        chk("t1_data_bus", bus_out, 8'hA5);
        @(negedge clk);
        chk("t1_write_ctrl", ctrl, 15'h0EE3);
        chk("t1_write_bus", bus_out, 8'hA5);
        @(negedge clk);
        chk("t1_inc_ctrl", ctrl, 15'h4FE3);
        chk("t1_count", byte_count, 1);
        @(negedge clk);
        chk("t1_back_armed", ctrl, 15'h0FE3);

        // two strobes two cycles apart
        start_session();
        strobe(8'h11);
        @(negedge clk);
        strobe(8'h22);
        repeat (12) @(negedge clk);
        chk("t2_count", byte_count, 2);
        chk("t2_overrun", overrun, 0);
        chk("t2_nwritten", written.size(), 2);
        if (written.size() == 2) begin
            chk("t2_w0", written[0], 8'h11);
            chk("t2_w1", written[1], 8'h22);
        end

        // three back-to-back strobes
        start_session();
        strobe(8'h33);
        strobe(8'h44);
        strobe(8'h55);
        repeat (14) @(negedge clk);
        chk("t3_count", byte_count, 2);
        chk("t3_overrun", overrun, 1);
        chk("t3_nwritten", written.size(), 2);
        if (written.size() == 2) begin
            chk("t3_w0", written[0], 8'h33);
            chk("t3_w1", written[1], 8'h44);
        end

        // fill to depth plus one
        start_session();
        for (int i = 0; i < DEPTH + 1; i++) begin
            strobe(8'(i + 1));
            repeat (4) @(negedge clk);
            if (i == DEPTH - 1) begin
                chk("t4_full_at16", full, 1);
                chk("t4_ovr_at16", overrun, 0);
            end
        end
        chk("t4_count", byte_count, DEPTH);
        chk("t4_overrun", overrun, 1);
        chk("t4_nwritten", written.size(), DEPTH);
        if (written.size() == DEPTH) begin
            for (int i = 0; i < DEPTH; i++) chk("t4_wbyte", written[i], i + 1);
        end

        // programming dropped during DATA
        start_session();
        strobe(8'h66);
        @(negedge clk);
        programming = 1'b0;
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("t5_done_pulses", dn, 1);
        chk("t5_count", byte_count, 1);
        chk("t5_idle_ctrl", ctrl, 15'h0FE3);
        chk("t5_idle_busy", busy, 0);

        // async reset during WRITE, programming held high through release
        start_session();
        strobe(8'h77);
        @(negedge clk);
        @(negedge clk);
        chk("t6_in_write", ctrl, 15'h0EE3);
        #2 resetn = 1'b0;
        #1;
        chk("t6_rst_ctrl", ctrl, 15'h0FE3);
        chk("t6_rst_oe", bus_oe, 0);
        chk("t6_rst_bus", bus_out, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_cnt", byte_count, 0);
        @(negedge clk);
        #2 resetn = 1'b1;
        repeat (8) @(negedge clk);
        chk("t6_no_session", busy, 0);
        chk("t6_idle_ctrl", ctrl, 15'h0FE3);
        programming = 1'b0;
        repeat (2) @(negedge clk);
        programming = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6_restart_busy", busy, 1);
        programming = 1'b0;
        repeat (6) @(negedge clk);

        // randomized sessions
        rate = 35;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 119) == 0) programming = ~programming;
            new_byte = ($urandom_range(0, 99) < rate);
            ui_in    = 8'($urandom);
            if ($urandom_range(0, 299) == 0) rate = $urandom_range(5, 70);
            if ($urandom_range(0, 1499) == 0) begin
                #2 resetn = 1'b0;
                @(negedge clk);
                #2 resetn = 1'b1;
            end
        end
        new_byte = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 Parameter RAM_DEPTH, default 16, SHALL set the number of program bytes accepted per session (power of two, 2..256).
REQ-002 Parameter CNT_W, default 5, SHALL be the byte_count width and SHALL equal log2(RAM_DEPTH)+1.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 resetn  in  1  SHALL be the reset: asynchronous assert, active-low.
REQ-005 ui_in  in  8  SHALL carry the program byte, valid in the cycle new_byte is high.
REQ-006 programming  in  1  SHALL be the level request for a load session (high = load, low = run).
REQ-007 new_byte  in  1  SHALL be a one-cycle strobe marking ui_in valid.
REQ-008 bus_out  out  8  SHALL be the value driven onto the shared 8-bit bus.
REQ-009 bus_oe  out  1  SHALL be the bus output enable; high only when the sequencer owns the bus.
REQ-010 ctrl  out  15  SHALL be the control word, using the CPU's bit map (14 PC_INC, 13 PC_EN, 12 PC_LOAD, 11 MAR_ADDR_LOAD_N, 10 MAR_MEM_LOAD_N, 9 RAM_EN_N, 8 RAM_LOAD_N, 7 IR_LOAD_N, 6 IR_EN_N, 5 REGA_LOAD_N, 4 REGA_EN, 3 ADDER_SUB, 2 REGB_EN, 1 REGB_LOAD_N, 0 OUT_LOAD_N).
REQ-011 busy  out  1  SHALL be high in every state except IDLE.
REQ-012 done  out  1  SHALL pulse for one cycle when a session ends.
REQ-013 byte_count  out  CNT_W  SHALL be the number of bytes written this session.
REQ-014 full  out  1  SHALL be high when byte_count equals RAM_DEPTH.
REQ-015 overrun  out  1  SHALL be a sticky flag for a dropped new_byte strobe.

Function
REQ-016 States SHALL be IDLE, CLEAR, ARMED, ADDR, DATA, WRITE, INC, FINISH; all outputs registered.
REQ-017 In IDLE, ctrl SHALL be 15'h0FE3 (all deasserted) and bus_oe SHALL be 0.
REQ-018 A rising edge of programming (sampled against a registered copy) in IDLE SHALL enter CLEAR: bus_oe=1, bus_out=8'h00, PC_LOAD=1 for one cycle; byte_count, full and overrun cleared; then ARMED.
REQ-019 In ARMED, new_byte=1 SHALL latch ui_in into an internal data register and enter ADDR the next cycle.
REQ-020 ADDR SHALL assert PC_EN=1, MAR_ADDR_LOAD_N=0 for one cycle.
REQ-021 DATA SHALL assert bus_oe=1, bus_out=latched byte, MAR_MEM_LOAD_N=0 for one cycle.
REQ-022 WRITE SHALL hold bus_oe=1, bus_out=latched byte and assert RAM_LOAD_N=0 for one cycle.
REQ-023 INC SHALL assert PC_INC=1, increment byte_count, and return to ARMED; new_byte-to-ARMED latency is exactly 5 cycles.
REQ-024 new_byte arriving in ADDR..INC SHALL be held in a one-deep pending slot (byte and flag); ARMED with pending set SHALL proceed to ADDR without waiting.
REQ-025 new_byte arriving while the pending slot is occupied SHALL be dropped and set overrun.
REQ-026 new_byte while full=1 SHALL be ignored and set overrun; no control activity.
REQ-027 new_byte and programming-low in the same ARMED cycle SHALL write that byte first, then end the session.
REQ-028 programming low in ARMED with no pending byte SHALL enter FINISH; programming low in ADDR..INC SHALL finish the current byte (and any pending byte) first.
REQ-029 FINISH SHALL pulse done=1 for one cycle, then IDLE; byte_count, full, overrun SHALL hold until the next CLEAR.
REQ-030 Any unencoded state SHALL recover to IDLE on the next clock.

Reset
REQ-031 resetn low SHALL asynchronously force IDLE, ctrl=15'h0FE3, bus_out=0, bus_oe=0, busy=0, done=0, byte_count=0, full=0, overrun=0, pending cleared, programming copy=0.
REQ-032 Reset mid-byte SHALL abort without completing the write; programming held high through reset release SHALL NOT start a session (no edge).

Structure
REQ-033 A shared package SHALL hold the 15 control-bit index constants, the idle word 15'h0FE3, and the state encoding.
REQ-034 One sub-module, prog_pending_slot (one-deep byte buffer with overrun detect), SHALL be instantiated; everything else stays flat.

Verification
REQ-035 Rise programming, new_byte with ui_in=8'hA5 -> CLEAR PC_LOAD with bus 8'h00, then ADDR/DATA(bus 8'hA5)/WRITE/INC on consecutive cycles, byte_count=1.
REQ-036 Strobes 2 cycles apart with 8'h11, 8'h22 -> both written in order, no overrun, byte_count=2.
REQ-037 Three strobes on consecutive cycles -> first two written, third dropped, overrun=1.
REQ-038 17 bytes at RAM_DEPTH=16 -> full=1 after 16th, 17th ignored with overrun=1, byte_count=16.
REQ-039 Drop programming during DATA -> byte completes, done pulses once after INC, IDLE ctrl=15'h0FE3.
REQ-040 Assert resetn=0 during WRITE -> all outputs at reset values asynchronously; no session until next programming rise.
